// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA timing generator with solid, colour-bar, checkerboard and
// external-pixel pattern modes. Pixel rate is set by pix_en; sync, blank and
// RGB travel through equal-depth delay lines so they stay aligned.
module vga_timing_pattern_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned COLOR_W    = 8,
    parameter int unsigned EXT_LAT    = 2,
    parameter int unsigned CHECK_LOG2 = 5,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW        = $clog2(H_TOTAL),
    localparam int unsigned VW        = $clog2(V_TOTAL)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    input  logic [3*COLOR_W-1:0]   ext_rgb,
    output logic [HW-1:0]          req_x,
    output logic [VW-1:0]          req_y,
    output logic                   req_valid,
    output logic                   vga_hs,
    output logic                   vga_vs,
    output logic                   vga_blank_n,
    output logic                   vga_sync_n,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b,
    output logic                   frame_start
);

    localparam int unsigned CW3   = 3 * COLOR_W;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    // Boundaries are one bit wider than the counters so an end value equal to the
    // total never wraps to zero.
    localparam logic [HW:0]   H_ACT_E = (HW+1)'(H_ACTIVE);
    localparam logic [HW:0]   H_SS    = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   H_SE    = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   V_ACT_E = (VW+1)'(V_ACTIVE);
    localparam logic [VW:0]   V_SS    = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   V_SE    = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

    // Position that the counter stage will load on the next pix_en tick.
    logic [HW-1:0]  nxt_h;
    logic [VW-1:0]  nxt_v;
    logic           nxt_act, nxt_hs, nxt_vs;

    // Counter stage (visible on req_x/req_y/req_valid).
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           stg_hs, stg_vs, stg_fs;

    logic [1:0]     shd_mode;
    logic [CW3-1:0] shd_solid;

    logic [CW3-1:0] pat_rgb;
    logic [HW-1:0]  bar_q;
    logic [2:0]     bar_idx;

    logic           dl_hs  [EXT_LAT];
    logic           dl_vs  [EXT_LAT];
    logic           dl_bl  [EXT_LAT];
    logic           dl_fs  [EXT_LAT];
    logic           dl_ext [EXT_LAT];
    logic [CW3-1:0] dl_rgb [EXT_LAT];

    logic [CW3-1:0] rgb_q;

    assign req_x      = h_cnt;
    assign req_y      = v_cnt;
    assign vga_sync_n = 1'b1;
    assign vga_r      = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign vga_g      = rgb_q[2*COLOR_W-1:COLOR_W];
    assign vga_b      = rgb_q[COLOR_W-1:0];

    // Region decode of the upcoming position.
    always_comb begin
        nxt_act = ({1'b0, nxt_h} < H_ACT_E) && ({1'b0, nxt_v} < V_ACT_E);
        nxt_hs  = (({1'b0, nxt_h} >= H_SS) && ({1'b0, nxt_h} < H_SE)) ? HS_POL : ~HS_POL;
        nxt_vs  = (({1'b0, nxt_v} >= V_SS) && ({1'b0, nxt_v} < V_SE)) ? VS_POL : ~VS_POL;
        stg_fs  = req_valid && (h_cnt == '0) && (v_cnt == '0);
    end

    // Raster counters and the counter stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nxt_h     <= '0;
            nxt_v     <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            req_valid <= 1'b0;
            stg_hs    <= ~HS_POL;
            stg_vs    <= ~VS_POL;
        end else if (pix_en) begin
            nxt_h <= (nxt_h == H_LAST) ? '0 : nxt_h + HW'(1);
            if (nxt_h == H_LAST) begin
                nxt_v <= (nxt_v == V_LAST) ? '0 : nxt_v + VW'(1);
            end
            h_cnt     <= nxt_h;
            v_cnt     <= nxt_v;
            req_valid <= nxt_act;
            stg_hs    <= nxt_hs;
            stg_vs    <= nxt_vs;
        end
    end

    // Mode/colour shadows update only as the stage leaves the last pixel of a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shd_mode  <= 2'd0;
            shd_solid <= '0;
        end else if (pix_en && (h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
            shd_mode  <= mode;
            shd_solid <= solid_rgb;
        end
    end

    // Internal pattern colour for the pixel in the counter stage.
    always_comb begin
        pat_rgb = '0;
        bar_q   = h_cnt / HW'(BAR_W);
        bar_idx = (bar_q > HW'(7)) ? 3'd7 : bar_q[2:0];
        case (shd_mode)
            2'd0: pat_rgb = shd_solid;
            2'd1: pat_rgb = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}},
                             {COLOR_W{~bar_idx[0]}}};
            2'd2: pat_rgb = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? '0 : '1;
            default: pat_rgb = '0;
        endcase
    end

    // Equal-depth delay line covering the external source latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < EXT_LAT; i++) begin
                dl_hs[i]  <= ~HS_POL;
                dl_vs[i]  <= ~VS_POL;
                dl_bl[i]  <= 1'b0;
                dl_fs[i]  <= 1'b0;
                dl_ext[i] <= 1'b0;
                dl_rgb[i] <= '0;
            end
        end else if (pix_en) begin
            dl_hs[0]  <= stg_hs;
            dl_vs[0]  <= stg_vs;
            dl_bl[0]  <= req_valid;
            dl_fs[0]  <= stg_fs;
            dl_ext[0] <= (shd_mode == 2'd3);
            dl_rgb[0] <= pat_rgb;
            for (int i = 1; i < EXT_LAT; i++) begin
                dl_hs[i]  <= dl_hs[i-1];
                dl_vs[i]  <= dl_vs[i-1];
                dl_bl[i]  <= dl_bl[i-1];
                dl_fs[i]  <= dl_fs[i-1];
                dl_ext[i] <= dl_ext[i-1];
                dl_rgb[i] <= dl_rgb[i-1];
            end
        end
    end

    // Output register: selects external pixel and forces black while blanked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
            rgb_q       <= '0;
        end else if (pix_en) begin
            vga_hs      <= dl_hs[EXT_LAT-1];
            vga_vs      <= dl_vs[EXT_LAT-1];
            vga_blank_n <= dl_bl[EXT_LAT-1];
            frame_start <= dl_fs[EXT_LAT-1];
            if (!dl_bl[EXT_LAT-1]) begin
                rgb_q <= '0;
            end else if (dl_ext[EXT_LAT-1]) begin
                rgb_q <= ext_rgb;
            end else begin
                rgb_q <= dl_rgb[EXT_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen: a raster model pushes expected output per
// pix_en tick into a queue (pre-filled with the reset state) and pops one per
// tick for comparison; a vector table checks specific pixels in each mode.
module tb_vga_timing_pattern_gen;

    localparam int HA = 640, HF = 16, HSW = 96, HB = 48;
    localparam int VA = 8, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int CL = 2;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [23:0] ext_rgb = 24'h0;
    logic [23:0] ext_d1 = 24'h0;
    logic [9:0]  req_x;
    logic [3:0]  req_y;
    logic        req_valid, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;

    vga_timing_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .EXT_LAT(2), .CHECK_LOG2(CL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
        .solid_rgb(solid_rgb), .ext_rgb(ext_rgb),
        .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // External source: returns {x, y, A5} two pix_en ticks after the request.
    always @(posedge clk) begin
        if (pix_en) begin
            ext_d1  <= {req_x[7:0], 4'h0, req_y, 8'hA5};
            ext_rgb <= ext_d1;
        end
    end

    typedef struct {
        logic        hs, vs, bl, fs;
        logic [23:0] rgb;
        int          x, y;
        logic [1:0]  md;
    } exp_t;

    typedef struct {
        logic [1:0]  md;
        int          x, y;
        logic [23:0] solid;
        logic        bl;
        logic [23:0] rgb;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    exp_t        q [$];
    exp_t        cur;
    int          mx, my;
    logic        last_end;
    logic [1:0]  sh_mode;
    logic [23:0] sh_solid;
    logic [9:0]  er_x;
    logic [3:0]  er_y;
    logic        er_v;

    int n_vec = 0, n_err = 0;
    int hs_low, vs_low, bl_hi;

    function automatic exp_t idle_entry();
        exp_t e;
        e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0; e.fs = 1'b0; e.rgb = 24'h0;
        e.x = -1; e.y = -1; e.md = 2'd0;
        return e;
    endfunction

    function automatic logic [23:0] exp_color(input logic [1:0] md, input logic [23:0] sol,
                                              input int x, input int y);
        int bi;
        logic [23:0] r;
        r = 24'h0;
        case (md)
            2'd0: r = sol;
            2'd1: begin
                bi = x / (HA / 8);
                if (bi > 7) bi = 7;
                case (bi)
                    0: r = 24'hFFFFFF;
                    1: r = 24'hFFFF00;
                    2: r = 24'h00FFFF;
                    3: r = 24'h00FF00;
                    4: r = 24'hFF00FF;
                    5: r = 24'hFF0000;
                    6: r = 24'h0000FF;
                    default: r = 24'h000000;
                endcase
            end
            2'd2: r = ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
            default: r = {x[7:0], y[7:0], 8'hA5};
        endcase
        return r;
    endfunction

    function automatic logic [47:0] pack_act();
        return {4'h0, vga_sync_n, vga_hs, vga_vs, vga_blank_n, frame_start,
                vga_r, vga_g, vga_b, req_x, req_y, req_valid};
    endfunction

    function automatic logic [47:0] pack_exp(input exp_t e);
        return {4'h0, 1'b1, e.hs, e.vs, e.bl, e.fs, e.rgb, er_x, er_y, er_v};
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; last_end = 1'b0;
        sh_mode = 2'd0; sh_solid = 24'h0;
        er_x = '0; er_y = '0; er_v = 1'b0;
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back(idle_entry());
        cur = idle_entry();
    endtask

    // Model of one pix_en tick: the pixel entering the counter stage.
    task automatic step();
        exp_t e;
        logic act;
        if (last_end) begin
            sh_mode  = mode;
            sh_solid = solid_rgb;
        end
        last_end = (mx == HT - 1) && (my == VT - 1);
        act  = (mx < HA) && (my < VA);
        e.x  = mx; e.y = my; e.md = sh_mode;
        e.hs = !((mx >= HA + HF) && (mx < HA + HF + HSW));
        e.vs = !((my >= VA + VF) && (my < VA + VF + VSW));
        e.bl = act;
        e.fs = (mx == 0) && (my == 0);
        e.rgb = act ? exp_color(sh_mode, sh_solid, mx, my) : 24'h0;
        er_x = 10'(mx); er_y = 4'(my); er_v = act;
        mx = mx + 1;
        if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end
        q.push_back(e);
        cur = q.pop_front();
    endtask

    task automatic tick(input logic en);
        pix_en = en;
        @(posedge clk);
        if (en) step();
        @(negedge clk);
        chk($sformatf("scoreboard x=%0d y=%0d", cur.x, cur.y), pack_act(), pack_exp(cur));
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (vga_blank_n) bl_hi++;
    endtask

    task automatic run_to(input int x, input int y, input logic [1:0] md);
        int budget;
        budget = 3 * HT * VT;
        while (!(cur.x == x && cur.y == y && cur.md == md) && budget > 0) begin
            tick(1'b1);
            budget--;
        end
        if (budget == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL run_to timeout: pixel (%0d,%0d) mode %0d never reached", x, y, md);
        end
    endtask

    task automatic check_fs_latency(input string nm);
        int n;
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            tick(1'b1);
            if (frame_start) n = i;
        end
        chk(nm, 48'(n), 48'd4);
    endtask

    task automatic set_vec(input int i, input logic [1:0] md, input int x, input int y,
                           input logic [23:0] sol, input logic bl, input logic [23:0] rgb);
        vt[i].md = md; vt[i].x = x; vt[i].y = y;
        vt[i].solid = sol; vt[i].bl = bl; vt[i].rgb = rgb;
    endtask

    initial begin
        set_vec(0,  2'd1, 0,   0, 24'h0,      1'b1, 24'hFFFFFF);
        set_vec(1,  2'd1, 80,  0, 24'h0,      1'b1, 24'hFFFF00);
        set_vec(2,  2'd1, 639, 0, 24'h0,      1'b1, 24'h000000);
        set_vec(3,  2'd1, 700, 0, 24'h0,      1'b0, 24'h000000);
        set_vec(4,  2'd1, 400, 2, 24'h0,      1'b1, 24'hFF0000);
        set_vec(5,  2'd1, 480, 2, 24'h0,      1'b1, 24'h0000FF);
        set_vec(6,  2'd2, 0,   0, 24'h0,      1'b1, 24'hFFFFFF);
        set_vec(7,  2'd2, 4,   0, 24'h0,      1'b1, 24'h000000);
        set_vec(8,  2'd2, 4,   4, 24'h0,      1'b1, 24'hFFFFFF);
        set_vec(9,  2'd2, 8,   5, 24'h0,      1'b1, 24'h000000);
        set_vec(10, 2'd3, 17,  3, 24'h0,      1'b1, 24'h1103A5);
        set_vec(11, 2'd3, 200, 7, 24'h0,      1'b1, 24'hC807A5);
        set_vec(12, 2'd0, 5,   5, 24'h123456, 1'b1, 24'h123456);
        set_vec(13, 2'd0, 650, 5, 24'h123456, 1'b0, 24'h000000);

        model_reset();
        hs_low = 0; vs_low = 0; bl_hi = 0;

        // Reset state, then first frame_start three ticks after the first counted tick.
        @(negedge clk);
        #1;
        chk("reset_state", pack_act(), pack_exp(idle_entry()));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_fs_latency("fs_latency_after_reset");

        // One full frame period of sync/blank occupancy; mode change requested mid-frame.
        hs_low = 0; vs_low = 0; bl_hi = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (i == 100) mode = 2'd1;
            tick(1'b1);
        end
        chk("hs_low_per_frame", 48'(hs_low), 48'(HSW * VT));
        chk("vs_low_per_frame", 48'(vs_low), 48'(VSW * HT));
        chk("blank_hi_per_frame", 48'(bl_hi), 48'(HA * VA));

        // Pixel vectors; each new mode is requested mid-frame after the last row of the old one.
        for (int i = 0; i < NV; i++) begin
            if (i > 0 && vt[i].md != vt[i-1].md) begin
                mode = vt[i].md;
                solid_rgb = vt[i].solid;
            end
            run_to(vt[i].x, vt[i].y, vt[i].md);
            chk($sformatf("vec%0d m%0d (%0d,%0d)", i, vt[i].md, vt[i].x, vt[i].y),
                {23'h0, vga_blank_n, vga_r, vga_g, vga_b}, {23'h0, vt[i].bl, vt[i].rgb});
        end

        // pix_en at half rate: periods in clocks double, outputs hold between ticks.
        hs_low = 0; vs_low = 0; bl_hi = 0;
        for (int i = 0; i < 2 * HT; i++) tick((i % 2) == 0);
        chk("hs_low_half_rate", 48'(hs_low), 48'(2 * HSW));
        chk("blank_hi_half_rate", 48'(bl_hi), 48'(2 * HA));

        // Reset in the middle of an active line; restart at (0,0) with black shadow.
        run_to(100, 7, 2'd0);
        reset = 1'b0;
        pix_en = 1'b0;
        #1;
        model_reset();
        chk("reset_mid_frame", pack_act(), pack_exp(idle_entry()));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_fs_latency("fs_latency_after_mid_reset");
        run_to(5, 0, 2'd0);
        chk("black_after_reset", {23'h0, vga_blank_n, vga_r, vga_g, vga_b}, {23'h0, 1'b1, 24'h0});
        for (int i = 0; i < 50; i++) tick(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
- Parametrised VGA timing and test-pattern engine; successor to the fixed 640x480 road-pattern driver.
- Generates sync, blank and RGB from any porch and sync geometry.
- Pixel rate is set by a clock-enable (no PLL inside), so one clock domain serves any mode.
- Provides solid, colour-bar, checkerboard and external-pixel modes, with sync/blank/RGB pipeline-aligned and mode changes applied only at frame boundaries.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, hsync active level
VS_POL, 0, vsync active level
COLOR_W, 8, bits per colour channel
EXT_LAT, 2, pix_en ticks from req_x/req_y to ext_rgb valid (>=1)
CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pix_en  in  1  pixel-rate enable; all counters and pipeline stages advance only when 1
mode  in  2  0 solid, 1 colour bars, 2 checkerboard, 3 external
solid_rgb  in  3*COLOR_W  {R,G,B} for mode 0
ext_rgb  in  3*COLOR_W  {R,G,B} from external source, mode 3
req_x  out  clog2(H_TOTAL)  counter-stage horizontal position
req_y  out  clog2(V_TOTAL)  counter-stage vertical position
req_valid  out  1  counter stage is in the active area
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_blank_n  out  1  1 during active video
vga_sync_n  out  1  constant 1
vga_r / vga_g / vga_b  out  COLOR_W each  pixel colour
frame_start  out  1  one pix_en tick pulse with the first active pixel at the output

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter order per line: active [0, H_ACTIVE), then FP, SYNC, BP. The same ordering applies vertically.
- Counters:
  - h_cnt increments on pix_en and wraps H_TOTAL-1 -> 0.
  - v_cnt increments on pix_en when h_cnt = H_TOTAL-1, and wraps V_TOTAL-1 -> 0.
- Sync is asserted at the active level when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync uses the equivalent v_cnt range. Otherwise the sync output is at !POL.
- req_x = h_cnt, req_y = v_cnt, req_valid = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE). All are registered counter-stage values.
- Output latency:
  - L = EXT_LAT+1 pix_en ticks, from the counter stage to every vga_* output and frame_start.
  - hs, vs, blank_n and RGB pass through equal-depth delay lines, so they are mutually aligned in all modes.
  - The pipeline holds its value when pix_en = 0.
- Shadow registers:
  - mode and solid_rgb are captured into shadow registers only on the pix_en tick where h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
  - Mid-frame changes are ignored until the next frame.
- Colour (computed from shadow mode, then delayed to match L):
  - Mode 0: solid_rgb.
  - Mode 1: 8 bars, each BW = H_ACTIVE/8 (integer division). Bar index = min(x/BW, 7). Order: white, yellow, cyan, green, magenta, red, blue, black, with full-scale channels (all ones / zero).
  - Mode 2: white if ((x>>CHECK_LOG2) ^ (y>>CHECK_LOG2)) bit0 = 0, else black.
  - Mode 3: ext_rgb, sampled EXT_LAT pix_en ticks after the matching req_x/req_y, then one register stage.
- Blanking: RGB forced to 0 whenever the output-stage blank_n = 0, in every mode.
- frame_start = 1 exactly on the output tick where the pixel at (0,0) is presented; 0 otherwise.
- Reset (asynchronous assert, synchronous-to-clk deassert is the integrator's responsibility):
  - h_cnt, v_cnt, shadow registers and all pipeline stages are cleared to 0 (sync stages cleared to !POL).
  - Output values during reset: vga_hs = !HS_POL, vga_vs = !VS_POL, blank_n = 0, RGB = 0, frame_start = 0, req_valid = 0, req_x = req_y = 0.
  - Shadow mode after reset = 0 with solid_rgb = 0, so the output is black until the first frame boundary.
- Reset mid-frame: restart from (0,0) immediately.
  - First frame_start occurs L pix_en ticks after the first pix_en following reset release.
  - First frame uses shadow = 0 (black).
- pix_en held 0: all outputs frozen. No pulse may be stretched or repeated.

Test Plan:
- Reset: assert reset=0 mid-frame with default params -> vga_hs=1, vga_vs=1, blank_n=0, RGB=0, frame_start=0. After release with pix_en=1, frame_start rises exactly 3 clocks (EXT_LAT=2) after the first counted tick.
- Timing, defaults, pix_en=1: hs low for 96 clocks every 800; vs low for 2 lines (1600 clocks) every 525 lines; blank_n high 640 of 800 clocks per line on 480 lines.
- pix_en toggling 1,0,1,0: every period measured in clk doubles (line = 1600 clocks). Sync, blank and RGB remain mutually aligned.
- Mode 1, mode set mid-frame: the current frame stays at the previous mode. In the next frame, output x=0 is FFFFFF, x=80 is FFFF00, x=639 is 000000, and blanking RGB is 000000.
- Mode 2, CHECK_LOG2=5: (0,0) white, (32,0) black, (32,32) white.
- Mode 3, ext model returning {x[7:0], y[7:0], 8'hA5} EXT_LAT ticks after the request: output pixel (17,3) = 11_03_A5, aligned with blank_n=1.
